snn_pattern_tx: RTL and testbench

SNN_PATTERN_TX -- requirements
Module: snn_pattern_tx

---
 rtl/snn_pattern_tx_pkg.sv | 39 +++
 rtl/snn_tx_store.sv | 63 ++++++
 rtl/snn_pattern_tx.sv | 145 ++++++++++++++
 tb/tb_snn_pattern_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pattern_tx_pkg.sv
// Shared types and sizes for the SNN pattern transmitter.
// Element counts and widths are also used by the SNN consumer.
package snn_pattern_tx_pkg;

  localparam int N_IMG  = 72;
  localparam int N_HALF = 36;
  localparam int N_KER  = 9;
  localparam int N_WGT  = 4;

  localparam int BYTE_W = 8;
  localparam int RES_W  = 10;
  localparam int LAT_W  = 8;
  localparam int ADDR_W = 7;
  localparam int KER_AW = 4;
  localparam int WGT_AW = 2;

  localparam logic [ADDR_W-1:0] LAST_BEAT =
    ADDR_W'(N_IMG - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } tx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] img;
    logic [BYTE_W-1:0] ker;
    logic [BYTE_W-1:0] weight;
  } beat_t;

  function automatic logic [LAT_W-1:0] sat_inc(
    input logic [LAT_W-1:0] v
  );
    return (&v) ? v : v + LAT_W'(1);
  endfunction

endpackage

// File: rtl/snn_tx_store.sv
// Pattern storage: 72 image, 9 kernel and 4 weight bytes.
// Read port forwards a same-cycle write so a load can feed beat 0.
module snn_tx_store
  import snn_pattern_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  beat_t             wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output beat_t             rd_data
);

  logic [BYTE_W-1:0] img_mem [N_IMG];
  logic [BYTE_W-1:0] ker_mem [N_KER];
  logic [BYTE_W-1:0] wgt_mem [N_WGT];

  logic img_we;
  logic ker_we;
  logic wgt_we;
  logic hit;

  assign img_we = wr_en
    && (wr_addr < ADDR_W'(N_IMG));
  assign ker_we = wr_en
    && (wr_addr < ADDR_W'(N_KER));
  assign wgt_we = wr_en
    && (wr_addr < ADDR_W'(N_WGT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IMG; i++)
        img_mem[i] <= '0;
      for (int i = 0; i < N_KER; i++)
        ker_mem[i] <= '0;
      for (int i = 0; i < N_WGT; i++)
        wgt_mem[i] <= '0;
    end else begin
      if (img_we)
        img_mem[wr_addr] <= wr_data.img;
      if (ker_we)
        ker_mem[wr_addr[KER_AW-1:0]] <= wr_data.ker;
      if (wgt_we)
        wgt_mem[wr_addr[WGT_AW-1:0]] <= wr_data.weight;
    end
  end

  always_comb begin
    rd_data = '0;
    hit = wr_en && (wr_addr == rd_idx);
    if (rd_idx < ADDR_W'(N_IMG))
      rd_data.img = hit ? wr_data.img
                        : img_mem[rd_idx];
    if (rd_idx < ADDR_W'(N_KER))
      rd_data.ker = hit ? wr_data.ker
                        : ker_mem[rd_idx[KER_AW-1:0]];
    if (rd_idx < ADDR_W'(N_WGT))
      rd_data.weight = hit ? wr_data.weight
                           : wgt_mem[rd_idx[WGT_AW-1:0]];
  end

endmodule

// File: rtl/snn_pattern_tx.sv
// Streams a stored image/kernel/weight pattern to an SNN core
// and captures its response value and latency.
module snn_pattern_tx
  import snn_pattern_tx_pkg::*;
#(
  parameter int TIMEOUT = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BYTE_W-1:0] ld_img,
  input  logic [BYTE_W-1:0] ld_ker,
  input  logic [BYTE_W-1:0] ld_weight,
  input  logic              start,
  output logic              in_valid,
  output logic [BYTE_W-1:0] img,
  output logic [BYTE_W-1:0] ker,
  output logic [BYTE_W-1:0] weight,
  input  logic              out_valid,
  input  logic [RES_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic [LAT_W-1:0]  latency,
  output logic              err_timeout,
  output logic              err_proto
);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [ADDR_W-1:0] beat_q;
  logic [ADDR_W-1:0] rd_idx;
  logic [LAT_W-1:0]  cnt_q;
  beat_t             rd_data;
  beat_t             tx_q;
  beat_t             wr_data;
  logic              wr_en;
  logic              last_beat;
  logic              to_hit;

  assign busy = (state_q == ST_SEND)
             || (state_q == ST_WAIT);
  assign done = (state_q == ST_DONE);

  assign wr_en   = ld_en && !busy;
  assign wr_data = '{img: ld_img,
                     ker: ld_ker,
                     weight: ld_weight};

  assign last_beat = (beat_q == LAST_BEAT);
  assign to_hit    = (cnt_q == LAT_W'(TIMEOUT));

  // Index of the beat to be registered at the next edge
  assign rd_idx = (state_q == ST_SEND)
                ? beat_q + ADDR_W'(1) : '0;

  snn_tx_store u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (ld_addr),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SEND;
      ST_SEND: if (last_beat) state_d = ST_WAIT;
      ST_WAIT:
        if (out_valid || to_hit)
          state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      in_valid    <= 1'b0;
      result      <= '0;
      latency     <= '0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            beat_q      <= '0;
            tx_q        <= rd_data;
            in_valid    <= 1'b1;
            result      <= '0;
            latency     <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (out_valid)
            err_proto <= 1'b1;
          if (last_beat) begin
            in_valid <= 1'b0;
            tx_q     <= '0;
            cnt_q    <= LAT_W'(1);
          end else begin
            beat_q <= rd_idx;
            tx_q   <= rd_data;
          end
        end
        ST_WAIT: begin
          // A response in the timeout cycle still wins
          if (out_valid) begin
            result  <= out_data;
            latency <= cnt_q;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            result      <= '0;
            latency     <= LAT_W'(TIMEOUT);
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign img    = tx_q.img;
  assign ker    = tx_q.ker;
  assign weight = tx_q.weight;

endmodule

// File: tb/tb_snn_pattern_tx.sv
// Bench for snn_pattern_tx: table of transfer vectors plus
// hand-written load/start/reset corner sequences.
module tb_snn_pattern_tx;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [6:0] ld_addr;
  logic [7:0] ld_img, ld_ker, ld_weight;
  logic       start;
  logic       in_valid;
  logic [7:0] img, ker, weight;
  logic       out_valid;
  logic [9:0] out_data;
  logic       busy, done;
  logic [9:0] result;
  logic [7:0] latency;
  logic       err_timeout, err_proto;

  always #5 clk = ~clk;

  snn_pattern_tx #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_img      (ld_img),
    .ld_ker      (ld_ker),
    .ld_weight   (ld_weight),
    .start       (start),
    .in_valid    (in_valid),
    .img         (img),
    .ker         (ker),
    .weight      (weight),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .latency     (latency),
    .err_timeout (err_timeout),
    .err_proto   (err_proto)
  );

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] k;
    logic [7:0] w;
  } exp_t;

  typedef struct {
    string      name;
    int         rwait;
    logic [9:0] rdata;
    int         pbeat;
    logic [9:0] eres;
    int         elat;
    bit         eto;
    bit         eproto;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_img [72];
  logic [7:0] m_ker [9];
  logic [7:0] m_wgt [4];
  exp_t       q [$];

  int opt_ign_beat = -1;
  bit opt_sim_ld   = 1'b0;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  function automatic void mdl_write(input int a,
    input logic [7:0] i, k, w);
    if (a < 72) m_img[a] = i;
    if (a < 9)  m_ker[a] = k;
    if (a < 4)  m_wgt[a] = w;
  endfunction

  function automatic void push_beats();
    exp_t e;
    for (int k = 0; k < 72; k++) begin
      e.i = m_img[k];
      e.k = (k < 9) ? m_ker[k] : 8'd0;
      e.w = (k < 4) ? m_wgt[k] : 8'd0;
      q.push_back(e);
    end
  endfunction

  // Caller is at a negedge
  task automatic load(input int a,
                      input logic [7:0] i, k, w);
    ld_en = 1'b1;
    ld_addr = 7'(a);
    ld_img = i;
    ld_ker = k;
    ld_weight = w;
    @(negedge clk);
    ld_en = 1'b0;
    mdl_write(a, i, k, w);
  endtask

  task automatic run_xfer(input string nm,
    input int rwait, input logic [9:0] rdata,
    input int pbeat, input logic [9:0] eres,
    input int elat, input bit eto, input bit eproto);
    int   nb  = 0;
    int   nw  = 0;
    int   cyc = 0;
    bit   fin = 1'b0;
    exp_t e;
    start = 1'b1;
    if (opt_sim_ld) begin
      ld_en = 1'b1;
      ld_addr = 7'd0;
      ld_img = 8'h77;
      ld_ker = 8'h88;
      ld_weight = 8'h99;
      mdl_write(0, 8'h77, 8'h88, 8'h99);
    end
    push_beats();
    @(negedge clk);
    while (!fin && cyc < 400) begin
      cyc++;
      out_valid = 1'b0;
      start = 1'b0;
      ld_en = 1'b0;
      if (in_valid) begin
        if (q.size() == 0) begin
          chk({nm, "_extra_beat"}, 32'(nb), 32'd72);
        end else begin
          e = q.pop_front();
          chk({nm, "_beat"},
              32'({img, ker, weight}), 32'(e));
        end
        if (nb == pbeat) begin
          out_valid = 1'b1;
          out_data = 10'h2AA;
        end
        if (nb == opt_ign_beat) begin
          start = 1'b1;
          ld_en = 1'b1;
          ld_addr = 7'd0;
          ld_img = 8'hEE;
          ld_ker = 8'hEE;
          ld_weight = 8'hEE;
        end
        nb++;
      end else if (done) begin
        fin = 1'b1;
        chk({nm, "_nbeats"}, 32'(nb), 32'd72);
        chk({nm, "_nwait"}, 32'(nw),
            32'((rwait > 0) ? rwait : TO));
        chk({nm, "_result"}, 32'(result), 32'(eres));
        chk({nm, "_latency"}, 32'(latency), 32'(elat));
        chk({nm, "_err_to"}, 32'(err_timeout), 32'(eto));
        chk({nm, "_err_pr"}, 32'(err_proto), 32'(eproto));
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_idle_zero"},
            32'({img, ker, weight}), 32'd0);
        // start during DONE must be ignored
        start = 1'b1;
      end else begin
        nw++;
        if (nw == 1)
          chk({nm, "_busy_wait"}, 32'(busy), 32'd1);
        if (nw == rwait) begin
          out_valid = 1'b1;
          out_data = rdata;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_valid = 1'b0;
    if (!fin)
      chk({nm, "_no_done_in_budget"}, 32'd0, 32'd1);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_no_relaunch"},
        32'({in_valid, busy}), 32'd0);
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time bound reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_img = '0;
    ld_ker = '0;
    ld_weight = '0;
    start = 1'b0;
    out_valid = 1'b0;
    out_data = '0;
    for (int k = 0; k < 72; k++) m_img[k] = '0;
    for (int k = 0; k < 9; k++)  m_ker[k] = '0;
    for (int k = 0; k < 4; k++)  m_wgt[k] = '0;

    vecs[0] = '{"resp40", 40, 10'd123, -1,
                10'd123, 40, 1'b0, 1'b0};
    vecs[1] = '{"timeout", 0, 10'd0, -1,
                10'd0, TO, 1'b1, 1'b0};
    vecs[2] = '{"proto", 5, 10'd5, 10,
                10'd5, 5, 1'b0, 1'b1};
    vecs[3] = '{"resp_at_to", TO, 10'h3FF, -1,
                10'h3FF, TO, 1'b0, 1'b0};
    vecs[4] = '{"resp1", 1, 10'h200, -1,
                10'h200, 1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_latency", 32'(latency), 32'd0);
    chk("rst_flags",
        32'({err_timeout, err_proto}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 72; k++)
      load(k, 8'(k), 8'(k + 100), 8'(k + 200));
    // Out-of-range address must not alias into any array
    ld_en = 1'b1;
    ld_addr = 7'd100;
    ld_img = 8'h5A;
    ld_ker = 8'h5B;
    ld_weight = 8'h5C;
    @(negedge clk);
    ld_en = 1'b0;

    for (int v = 0; v < 5; v++)
      run_xfer(vecs[v].name, vecs[v].rwait,
               vecs[v].rdata, vecs[v].pbeat,
               vecs[v].eres, vecs[v].elat,
               vecs[v].eto, vecs[v].eproto);

    opt_ign_beat = 20;
    run_xfer("busy_ignore", 7, 10'd77, -1,
             10'd77, 7, 1'b0, 1'b0);
    opt_ign_beat = -1;
    run_xfer("after_ignore", 3, 10'd33, -1,
             10'd33, 3, 1'b0, 1'b0);

    opt_sim_ld = 1'b1;
    run_xfer("load_start", 2, 10'd9, -1,
             10'd9, 2, 1'b0, 1'b0);
    opt_sim_ld = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_send_valid", 32'(in_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(in_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || in_valid) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    for (int k = 0; k < 72; k++) m_img[k] = '0;
    for (int k = 0; k < 9; k++)  m_ker[k] = '0;
    for (int k = 0; k < 4; k++)  m_wgt[k] = '0;
    run_xfer("zero_image", 4, 10'd44, -1,
             10'd44, 4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
